// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_fifo
// Description : PS/2 device-to-host frame receiver with input synchronisers,
//               PS/2 clock glitch filter, configurable data width and parity,
//               in-frame timeout abort and a first-word-fall-through FIFO.
//
// Ports       : CLK, RESET          system clock, async active-high reset
//               CLK_MOUSE_IN        raw PS/2 clock line
//               DATA_MOUSE_IN       raw PS/2 data line
//               READ_ENABLE         permits a new frame to start
//               BYTE_ACK            pops FIFO head when BYTE_VALID=1
//               CLR_OVERFLOW        clears OVERFLOW
//               BYTE_READ           FIFO head data
//               BYTE_ERROR_CODE     FIFO head status (bit0 parity, bit1 stop)
//               BYTE_VALID          FIFO not empty
//               FIFO_COUNT          FIFO occupancy
//               OVERFLOW            sticky: completed frame dropped (FIFO full)
//               TIMEOUT_PULSE       one-cycle pulse on timeout abort
//               FRAME_CNT, ERR_CNT  frame / error statistics
//
// Options     : define PS2_RX_STATS_EN to build the saturating 16-bit
//               FRAME_CNT / ERR_CNT counters; otherwise both are tied to 0.
//
// Revision    : 1.0  initial release
// ============================================================================
module ps2_rx_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,      // 0 odd, 1 even, 2 none
    parameter int T_TIMEOUT   = 50000,
    parameter int FILTER_LEN  = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          CLK_MOUSE_IN,
    input  logic                          DATA_MOUSE_IN,
    input  logic                          READ_ENABLE,
    input  logic                          BYTE_ACK,
    input  logic                          CLR_OVERFLOW,
    output logic [DATA_BITS-1:0]          BYTE_READ,
    output logic [1:0]                    BYTE_ERROR_CODE,
    output logic                          BYTE_VALID,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          OVERFLOW,
    output logic                          TIMEOUT_PULSE,
    output logic [15:0]                   FRAME_CNT,
    output logic [15:0]                   ERR_CNT
);

    localparam int c_filt_w = $clog2(FILTER_LEN + 1);
    localparam int c_bit_w  = $clog2(DATA_BITS + 1);
    localparam int c_to_w   = $clog2(T_TIMEOUT + 1);
    localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_ent_w  = DATA_BITS + 2;

    localparam logic [c_filt_w-1:0] c_filt_last = c_filt_w'(FILTER_LEN - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DATA_BITS - 1);
    localparam logic [c_to_w-1:0]   c_to_last   = c_to_w'(T_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0]          r_sync_clk;
    logic [1:0]          r_sync_dat;
    logic                r_filt;
    logic                r_filt_d;
    logic [c_filt_w-1:0] r_filt_cnt;
    logic                w_clk_s;
    logic                w_dat_s;
    logic                w_edge;

    assign w_clk_s = r_sync_clk[1];
    assign w_dat_s = r_sync_dat[1];
    assign w_edge  = r_filt_d & ~r_filt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sync_clk <= 2'b11;
            r_sync_dat <= 2'b11;
            r_filt     <= 1'b1;
            r_filt_d   <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_sync_clk <= {r_sync_clk[0], CLK_MOUSE_IN};
            r_sync_dat <= {r_sync_dat[0], DATA_MOUSE_IN};
            r_filt_d   <= r_filt;
            // Count consecutive samples that disagree with the filtered
            // value; any agreeing sample restarts the count.
            if (w_clk_s != r_filt) begin
                if (r_filt_cnt == c_filt_last) begin
                    r_filt     <= w_clk_s;
                    r_filt_cnt <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + 1'b1;
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP   = 3'd3,
        S_PUSH   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_timeout;
    logic                 w_start;
    logic                 w_in_frame;
    logic                 w_par_exp;
    logic [DATA_BITS-1:0] r_shift;
    logic [c_bit_w-1:0]   r_bit_cnt;
    logic [1:0]           r_status;
    logic [c_to_w-1:0]    r_to_cnt;

    assign w_start    = (r_state == S_IDLE) && w_edge && READ_ENABLE && !w_dat_s;
    assign w_in_frame = (r_state == S_DATA) || (r_state == S_PARITY) ||
                        (r_state == S_STOP);
    // Parity bit the device should send for the captured data
    assign w_par_exp  = (PARITY_MODE == 1) ? (^r_shift) : (~^r_shift);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_edge) begin
                    if (r_bit_cnt == c_bit_last) begin
                        w_state_nxt = (PARITY_MODE == 2) ? S_STOP : S_PARITY;
                    end
                end else if (r_to_cnt == c_to_last) begin
                    w_state_nxt = S_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            S_PARITY: begin
                if (w_edge) begin
                    w_state_nxt = S_STOP;
                end else if (r_to_cnt == c_to_last) begin
                    w_state_nxt = S_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            S_STOP: begin
                if (w_edge) begin
                    w_state_nxt = S_PUSH;
                end else if (r_to_cnt == c_to_last) begin
                    w_state_nxt = S_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            S_PUSH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign TIMEOUT_PULSE = w_timeout;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_status  <= 2'b00;
            r_to_cnt  <= '0;
        end else begin
            if (w_in_frame && !w_edge) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end

            if (w_start) begin
                r_bit_cnt <= '0;
                r_status  <= 2'b00;
            end

            if (w_edge && (r_state == S_DATA)) begin
                // LSB arrives first: shift right, new bit enters at the MSB
                r_shift   <= DATA_BITS'({w_dat_s, r_shift} >> 1);
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (w_edge && (r_state == S_PARITY) && (w_dat_s != w_par_exp)) begin
                r_status[0] <= 1'b1;
            end

            if (w_edge && (r_state == S_STOP) && !w_dat_s) begin
                r_status[1] <= 1'b1;
            end

            // An aborted frame must not leak its status into the next one
            if ((r_state == S_PUSH) || w_timeout) begin
                r_status <= 2'b00;
            end
        end
    end

    // ------------------------------------------------------------------
    // FWFT FIFO
    // ------------------------------------------------------------------
    logic [c_ent_w-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_overflow;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_wr;
    logic [c_ent_w-1:0] w_head;

    assign w_push = (r_state == S_PUSH);
    assign w_full = (r_count == c_depth);
    assign w_pop  = BYTE_ACK && (r_count != '0);
    // A simultaneous pop frees the slot, so a push into a full FIFO succeeds
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {r_status, r_shift};
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (CLR_OVERFLOW) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign w_head          = r_mem[r_rd_ptr];
    assign BYTE_VALID      = (r_count != '0);
    assign BYTE_READ       = BYTE_VALID ? w_head[DATA_BITS-1:0] : '0;
    assign BYTE_ERROR_CODE = BYTE_VALID ? w_head[c_ent_w-1 -: 2] : 2'b00;
    assign FIFO_COUNT      = r_count;
    assign OVERFLOW        = r_overflow;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef PS2_RX_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_err_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_push && (r_frame_cnt != 16'hFFFF)) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (((w_push && (r_status != 2'b00)) || w_timeout) &&
                (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign FRAME_CNT = r_frame_cnt;
    assign ERR_CNT   = r_err_cnt;
`else
    assign FRAME_CNT = '0;
    assign ERR_CNT   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_rx_fifo
// Description : Directed self-checking bench for ps2_rx_fifo. Instance u_dut
//               is 8-bit odd parity; u_dut7 is 7-bit with no parity slot.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_rx_fifo;

    localparam int H = 20;      // PS/2 half period in CLK cycles
    localparam int T = 200;     // timeout in CLK cycles

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2c_a = 1'b1, ps2d_a = 1'b1;
    logic ps2c_b = 1'b1, ps2d_b = 1'b1;
    logic read_en = 1'b1;
    logic ack_a = 1'b0, ack_b = 1'b0;
    logic clr_ovf = 1'b0;

    logic [7:0]  byte_a;
    logic [1:0]  code_a;
    logic        valid_a;
    logic [2:0]  count_a;
    logic        ovf_a;
    logic        to_a;
    logic [15:0] fcnt_a, ecnt_a;

    logic [6:0]  byte_b;
    logic [1:0]  code_b;
    logic        valid_b;
    logic [2:0]  count_b;
    logic        ovf_b;
    logic        to_b;
    logic [15:0] fcnt_b, ecnt_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ps2_rx_fifo #(.DATA_BITS(8), .PARITY_MODE(0), .T_TIMEOUT(T),
                  .FILTER_LEN(4), .FIFO_DEPTH(4)) u_dut (
        .CLK(clk), .RESET(rst), .CLK_MOUSE_IN(ps2c_a), .DATA_MOUSE_IN(ps2d_a),
        .READ_ENABLE(read_en), .BYTE_ACK(ack_a), .CLR_OVERFLOW(clr_ovf),
        .BYTE_READ(byte_a), .BYTE_ERROR_CODE(code_a), .BYTE_VALID(valid_a),
        .FIFO_COUNT(count_a), .OVERFLOW(ovf_a), .TIMEOUT_PULSE(to_a),
        .FRAME_CNT(fcnt_a), .ERR_CNT(ecnt_a)
    );

    ps2_rx_fifo #(.DATA_BITS(7), .PARITY_MODE(2), .T_TIMEOUT(T),
                  .FILTER_LEN(4), .FIFO_DEPTH(4)) u_dut7 (
        .CLK(clk), .RESET(rst), .CLK_MOUSE_IN(ps2c_b), .DATA_MOUSE_IN(ps2d_b),
        .READ_ENABLE(read_en), .BYTE_ACK(ack_b), .CLR_OVERFLOW(clr_ovf),
        .BYTE_READ(byte_b), .BYTE_ERROR_CODE(code_b), .BYTE_VALID(valid_b),
        .FIFO_COUNT(count_b), .OVERFLOW(ovf_b), .TIMEOUT_PULSE(to_b),
        .FRAME_CNT(fcnt_b), .ERR_CNT(ecnt_b)
    );

    // ---------------- stimulus helpers ----------------
    task automatic set_c(input bit sel, input logic v);
        if (sel) ps2c_b = v; else ps2c_a = v;
    endtask

    task automatic set_d(input bit sel, input logic v);
        if (sel) ps2d_b = v; else ps2d_a = v;
    endtask

    // One PS/2 bit: data set while clock high, then a full low phase.
    // With glitch=1 a 2-cycle low pulse is injected mid high phase.
    task automatic send_bit(input bit sel, input logic b, input bit glitch);
        @(negedge clk); set_d(sel, b);
        repeat (H/2) @(negedge clk);
        if (glitch) begin
            set_c(sel, 1'b0);
            repeat (2) @(negedge clk);
            set_c(sel, 1'b1);
        end
        repeat (H/2) @(negedge clk);
        set_c(sel, 1'b0);
        repeat (H) @(negedge clk);
        set_c(sel, 1'b1);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] data, input int nbits,
                              input bit has_par, input logic par, input bit do_stop,
                              input logic stop, input bit glitch);
        send_bit(sel, 1'b0, glitch);
        for (int i = 0; i < nbits; i++) send_bit(sel, data[i], glitch);
        if (has_par) send_bit(sel, par, glitch);
        if (do_stop) begin
            send_bit(sel, stop, glitch);
            @(negedge clk); set_d(sel, 1'b1);
            repeat (H) @(negedge clk);
        end
    endtask

    task automatic pop_a();
        @(negedge clk); ack_a = 1'b1;
        @(negedge clk); ack_a = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_a); end
        checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", ovf_a); end
        checks++; if (byte_a !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h expected 00", byte_a); end
        checks++; if (code_a !== 2'b00) begin errors++; $display("FAIL reset_code: got %b expected 00", code_a); end
        checks++; if (to_a !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", to_a); end
        checks++; if (fcnt_a !== 16'd0 || ecnt_a !== 16'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", fcnt_a, ecnt_a); end
    endtask

    task automatic test_errors();
        do_reset();
        send_frame(1'b0, 8'h3C, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);   // bad parity
        send_frame(1'b0, 8'h3C, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);   // bad stop
        checks++; if (count_a !== 3'd2) begin errors++; $display("FAIL err_count: got %0d expected 2", count_a); end
        checks++; if (byte_a !== 8'h3C || code_a !== 2'b01) begin errors++; $display("FAIL err_parity: got %h/%b expected 3c/01", byte_a, code_a); end
        pop_a();
        checks++; if (byte_a !== 8'h3C || code_a !== 2'b10) begin errors++; $display("FAIL err_stop: got %h/%b expected 3c/10", byte_a, code_a); end
        pop_a();
`ifdef PS2_RX_STATS_EN
        checks++; if (fcnt_a !== 16'd2 || ecnt_a !== 16'd2) begin errors++; $display("FAIL err_stats: got %0d/%0d expected 2/2", fcnt_a, ecnt_a); end
`else
        checks++; if (fcnt_a !== 16'd0 || ecnt_a !== 16'd0) begin errors++; $display("FAIL err_stats_off: got %0d/%0d expected 0/0", fcnt_a, ecnt_a); end
`endif
    endtask

    task automatic test_basic();
        send_frame(1'b0, 8'hA5, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        // stop bit driven by hand to time the push latency
        @(negedge clk); ps2d_a = 1'b1;
        repeat (H) @(negedge clk);
        ps2c_a = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (n == 7) begin
                checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL lat_early: got %b expected 0", valid_a); end
            end
            if (n == 8) begin
                checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b expected 1", valid_a); end
            end
        end
        repeat (H) @(negedge clk);
        ps2c_a = 1'b1;
        repeat (H) @(negedge clk);
        checks++; if (byte_a !== 8'hA5 || code_a !== 2'b00) begin errors++; $display("FAIL basic_data: got %h/%b expected a5/00", byte_a, code_a); end
        checks++; if (count_a !== 3'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", count_a); end
        pop_a();
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL basic_pop: got %b expected 0", valid_a); end
        pop_a();   // ack while empty is ignored
        checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL empty_ack: got %0d expected 0", count_a); end
    endtask

    task automatic test_overflow();
        logic [7:0] par_tab;
        par_tab = 8'b0001_0100;   // odd-parity bits for 0x01..0x05 at index 0..4
        for (int i = 0; i < 5; i++)
            send_frame(1'b0, 8'(i + 1), 8, 1'b1, par_tab[i], 1'b1, 1'b1, 1'b0);
        checks++; if (count_a !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", count_a); end
        checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf_a); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (byte_a !== 8'(i + 1)) begin errors++; $display("FAIL ovf_pop%0d: got %h expected %h", i, byte_a, 8'(i + 1)); end
            pop_a();
        end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b expected 0", valid_a); end
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf_a); end
    endtask

    task automatic test_timeout();
        int first = 0;
        int pulses = 0;
        do_reset();
        send_bit(1'b0, 1'b0, 1'b0);   // start
        send_bit(1'b0, 1'b0, 1'b0);   // data bit 0
        send_bit(1'b0, 1'b1, 1'b0);   // data bit 1
        @(negedge clk); ps2d_a = 1'b0; // data bit 2, last edge before stall
        repeat (H) @(negedge clk);
        ps2c_a = 1'b0;
        for (int n = 1; n <= T + 40; n++) begin
            @(posedge clk); #1;
            if (n == H) ps2c_a = 1'b1;
            if (to_a === 1'b1) begin
                pulses++;
                if (first == 0) first = n;
            end
        end
        // edge pulse follows 2 sync + 4 filter samples, timeout T cycles later
        checks++; if (first != 6 + T) begin errors++; $display("FAIL to_timing: got %0d expected %0d", first, 6 + T); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL to_width: got %0d expected 1", pulses); end
        checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL to_nopush: got %0d expected 0", count_a); end
        @(negedge clk); ps2d_a = 1'b1;
        send_frame(1'b0, 8'h5A, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++; if (byte_a !== 8'h5A || code_a !== 2'b00 || count_a !== 3'd1) begin errors++; $display("FAIL to_recover: got %h/%b/%0d expected 5a/00/1", byte_a, code_a, count_a); end
`ifdef PS2_RX_STATS_EN
        checks++; if (fcnt_a !== 16'd1 || ecnt_a !== 16'd1) begin errors++; $display("FAIL to_stats: got %0d/%0d expected 1/1", fcnt_a, ecnt_a); end
`endif
        pop_a();
    endtask

    task automatic test_glitch();
        send_frame(1'b0, 8'hC3, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++; if (count_a !== 3'd1) begin errors++; $display("FAIL glitch_count: got %0d expected 1", count_a); end
        checks++; if (byte_a !== 8'hC3 || code_a !== 2'b00) begin errors++; $display("FAIL glitch_data: got %h/%b expected c3/00", byte_a, code_a); end
        pop_a();
    endtask

    task automatic test_read_enable();
        read_en = 1'b0;
        send_frame(1'b0, 8'h77, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL rden_gate: got %0d expected 0", count_a); end
        read_en = 1'b1;
    endtask

    task automatic test_mode2_reset();
        send_frame(1'b1, 8'h55, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (byte_b !== 7'h55 || code_b !== 2'b00 || count_b !== 3'd1) begin errors++; $display("FAIL m2_data: got %h/%b/%0d expected 55/00/1", byte_b, code_b, count_b); end
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (valid_b !== 1'b0 || count_b !== 3'd0) begin errors++; $display("FAIL m2_reset: got %b/%0d expected 0/0", valid_b, count_b); end
        rst = 1'b0;
        ps2d_b = 1'b1;
        send_frame(1'b1, 8'h2B, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (byte_b !== 7'h2B || count_b !== 3'd1) begin errors++; $display("FAIL m2_after: got %h/%0d expected 2b/1", byte_b, count_b); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_errors();
        test_basic();
        test_overflow();
        test_timeout();
        test_glitch();
        test_read_enable();
        test_mode2_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $finish;
    end

endmodule
`default_nettype wire
